// File: rtl/bram_read_arbiter_pkg.sv
// Shared constants and requester indices for the QR frame-buffer image pipeline.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
// Ports: none.
package qr_pkg;

   localparam int FRAME_WIDTH       = 480;
   localparam int FRAME_HEIGHT      = 480;
   localparam int ADDR_WIDTH        = 19;
   localparam int BRAM_READ_LATENCY = 2;
   localparam int NUM_REQUESTERS    = 3;

   // Fixed slot of each image-processing stage on the shared read port.
   typedef enum logic [1:0] {
      REQ_AVERAGE = 2'd0,
      REQ_FINDER  = 2'd1,
      REQ_SAMPLER = 2'd2
   } req_idx_e;

endpackage

// File: rtl/bram_read_arbiter_if.sv
// Bundle of requester, BRAM and return signals around the frame-buffer read arbiter.
// Latency: none, wiring only.
// Backpressure: requesters hold req/addr until their grant strobe; returns cannot be stalled.
// Ports: slave = arbiter side, master = requesters plus BRAM side.
interface bram_read_arbiter_if #(
   parameter int NUM_REQ    = qr_pkg::NUM_REQUESTERS,
   parameter int ADDR_WIDTH = qr_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = 1
);

   logic [NUM_REQ-1:0]            req_in;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in;
   logic [NUM_REQ-1:0]            grant_out;
   logic [ADDR_WIDTH-1:0]         bram_addr_out;
   logic [DATA_WIDTH-1:0]         bram_data_in;
   logic [DATA_WIDTH-1:0]         rd_data_out;
   logic [NUM_REQ-1:0]            rd_valid_out;
   logic                          idle_out;

   modport slave (
      input  req_in, req_addr_in, bram_data_in,
      output grant_out, bram_addr_out, rd_data_out, rd_valid_out, idle_out
   );

   modport master (
      output req_in, req_addr_in, bram_data_in,
      input  grant_out, bram_addr_out, rd_data_out, rd_valid_out, idle_out
   );

endinterface

// File: rtl/bram_read_arbiter_tag_pipe.sv
// Shift register of {valid, requester index} that tracks reads inside the BRAM.
// Latency: DEPTH cycles from vld_i/idx_i to vld_o/idx_o.
// Backpressure: none; advances every cycle, clr_i drops every entry.
// Ports: clk_i, clr_i (sync clear), vld_i/idx_i (issued read), vld_o/idx_o (read leaving),
//        inflight_d_o (some entry will be valid after this edge).
module read_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int IDX_W = 2
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             vld_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             vld_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             inflight_d_o
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [IDX_W-1:0] idx_q [DEPTH];
   logic [IDX_W-1:0] idx_d [DEPTH];

   always_comb begin
      vld_d    = '0;
      idx_d    = '{default: '0};
      vld_d[0] = vld_i;
      idx_d[0] = idx_i;
      for (int s = 1; s < DEPTH; s++) begin
         vld_d[s] = vld_q[s-1];
         idx_d[s] = idx_q[s-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         vld_q <= '0;
         idx_q <= '{default: '0};
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   assign vld_o        = vld_q[DEPTH-1];
   assign idx_o        = idx_q[DEPTH-1];
   // Looking at next-state contents lets the idle flag stay a plain register.
   assign inflight_d_o = |vld_d;

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of the frame-buffer BRAM read port, one registered grant per cycle.
// Latency: grant and address registered at edge E, data and one-hot valid registered at E+READ_LATENCY+1.
// Backpressure: requesters hold req/addr until granted; a requester is masked the edge after its grant.
// Ports: clk_in, rst_in (sync, active high), bus (slave modport: req/addr in, grant, BRAM addr/data,
//        returned data with one-hot valid, idle).
module bram_read_arbiter #(
   parameter int NUM_REQ      = qr_pkg::NUM_REQUESTERS,
   parameter int ADDR_WIDTH   = qr_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH   = 1,
   parameter int READ_LATENCY = qr_pkg::BRAM_READ_LATENCY
) (
   input  logic               clk_in,
   input  logic               rst_in,
   bram_read_arbiter_if.slave bus
);

   import qr_pkg::*;

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]      gidx_q, gidx_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
   logic                  idle_q, idle_d;

   logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
   logic [NUM_REQ-1:0]    eligible;
   logic                  found;
   logic [PTR_W-1:0]      win;
   logic [PTR_W-1:0]      scan;

   logic                  pipe_vld;
   logic [PTR_W-1:0]      pipe_idx;
   logic                  inflight_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      assign req_addr[g] = bus.req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // A requester granted last edge is masked so it can update req/addr without double issue.
   assign eligible = bus.req_in & ~grant_q;

   // Scan from rr_ptr upward with explicit wrap, since NUM_REQ need not be a power of two.
   always_comb begin
      found = 1'b0;
      win   = '0;
      scan  = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && eligible[scan]) begin
            found = 1'b1;
            win   = scan;
         end
         scan = (scan == PTR_W'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
      end
   end

   always_comb begin
      grant_d  = '0;
      gidx_d   = gidx_q;
      addr_d   = addr_q;
      rr_ptr_d = rr_ptr_q;
      if (found) begin
         grant_d  = NUM_REQ'(1) << win;
         gidx_d   = win;
         addr_d   = req_addr[win];
         rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

   // Tag enters the pipe one edge after the grant, in step with the BRAM's own address register.
   read_tag_pipe #(
      .DEPTH (READ_LATENCY),
      .IDX_W (PTR_W)
   ) u_tag_pipe (
      .clk_i        (clk_in),
      .clr_i        (rst_in),
      .vld_i        (|grant_q),
      .idx_i        (gidx_q),
      .vld_o        (pipe_vld),
      .idx_o        (pipe_idx),
      .inflight_d_o (inflight_d)
   );

   always_comb begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      if (pipe_vld) begin
         rd_valid_d = NUM_REQ'(1) << pipe_idx;
         rd_data_d  = bus.bram_data_in;
      end
      idle_d = (grant_d == '0) && !inflight_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         grant_q    <= '0;
         gidx_q     <= '0;
         addr_q     <= '0;
         rr_ptr_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         idle_q     <= 1'b1;
      end else begin
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         addr_q     <= addr_d;
         rr_ptr_q   <= rr_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         idle_q     <= idle_d;
      end
   end

   assign bus.grant_out     = grant_q;
   assign bus.bram_addr_out = addr_q;
   assign bus.rd_data_out   = rd_data_q;
   assign bus.rd_valid_out  = rd_valid_q;
   assign bus.idle_out      = idle_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for the frame-buffer read arbiter with a 2-cycle BRAM model and a cycle reference model.
// Latency: directed patterns plus a long randomized run with a return scoreboard.
// Backpressure: requesters follow the hold-until-grant contract, with random withdrawals.
module tb_bram_read_arbiter;

   localparam int N  = 3;
   localparam int AW = 19;
   localparam int DW = 1;
   localparam int VW = N + AW + N + DW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_v = '0;
   logic [AW-1:0] addr_v [N];
   logic [AW-1:0] bram_a1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: expected outputs plus grant history for the return path.
   logic [N-1:0]  m_grant, m_h1, m_h2, m_rdv;
   logic [AW-1:0] m_addr, m_ha1, m_ha2;
   logic [DW-1:0] m_rdd;
   logic          m_idle;
   int            m_ptr;

   bram_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bram_read_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   assign bus.req_in      = req_v;
   assign bus.req_addr_in = {addr_v[2], addr_v[1], addr_v[0]};

   wire [VW-1:0] obs_vec = {bus.grant_out, bus.bram_addr_out, bus.rd_valid_out, bus.rd_data_out, bus.idle_out};
   wire [VW-1:0] exp_vec = {m_grant, m_addr, m_rdv, m_rdd, m_idle};

   always #5 clk = ~clk;

   function automatic logic bram_fn(input logic [AW-1:0] a);
      return a[0] ^ a[3];
   endfunction

   // Two-stage BRAM: address register, then output register.
   always_ff @(posedge clk) begin
      bram_a1          <= bus.bram_addr_out;
      bus.bram_data_in <= bram_fn(bram_a1);
   end

   task automatic tick();
      int           w;
      logic [N-1:0] elig;
      @(posedge clk);
      if (rst) begin
         m_grant = '0; m_h1 = '0; m_h2 = '0; m_rdv = '0;
         m_addr = '0; m_ha1 = '0; m_ha2 = '0;
         m_rdd = '0; m_idle = 1'b1; m_ptr = 0;
      end else begin
         elig = req_v & ~m_grant;
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         m_rdv = m_h2;
         if (m_h2 != '0) m_rdd = bram_fn(m_ha2);
         m_idle = (w < 0) && (m_grant == '0) && (m_h1 == '0);
         m_h2 = m_h1; m_ha2 = m_ha1;
         m_h1 = m_grant; m_ha1 = m_addr;
         if (w >= 0) begin
            m_grant = N'(1) << w;
            m_addr  = addr_v[w];
            m_ptr   = (w + 1) % N;
         end else begin
            m_grant = '0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_v = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (bus.grant_out !== 3'b000) begin n_fail++; $display("FAIL reset_grant got=%b exp=000", bus.grant_out); end
      n_checks++; if (bus.bram_addr_out !== 19'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.bram_addr_out); end
      n_checks++; if (bus.rd_valid_out !== 3'b000) begin n_fail++; $display("FAIL reset_rdv got=%b exp=000", bus.rd_valid_out); end
      n_checks++; if (bus.rd_data_out !== 1'b0) begin n_fail++; $display("FAIL reset_rdd got=%b exp=0", bus.rd_data_out); end
      n_checks++; if (bus.idle_out !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", bus.idle_out); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [N-1:0] g [13];
      logic [N-1:0] rv [13];
      logic         rd [13];
      do_reset();
      addr_v[0] = 19'd1000;
      req_v = 3'b001;
      for (int c = 1; c <= 12; c++) begin
         tick();
         g[c] = bus.grant_out; rv[c] = bus.rd_valid_out; rd[c] = bus.rd_data_out;
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
      n_checks++; if (g[1] !== 3'b001) begin n_fail++; $display("FAIL single_g1 got=%b exp=001", g[1]); end
      n_checks++; if (g[2] !== 3'b000) begin n_fail++; $display("FAIL single_g2 got=%b exp=000", g[2]); end
      n_checks++; if (g[3] !== 3'b001) begin n_fail++; $display("FAIL single_g3 got=%b exp=001", g[3]); end
      n_checks++; if (rv[4] !== 3'b001 || rd[4] !== 1'b1) begin n_fail++; $display("FAIL single_ret4 got=%b/%b exp=001/1", rv[4], rd[4]); end
      n_checks++; if (rv[5] !== 3'b000) begin n_fail++; $display("FAIL single_ret5 got=%b exp=000", rv[5]); end
   endtask

   task automatic test_all_three();
      logic [N-1:0]  eg;
      logic [AW-1:0] ea;
      do_reset();
      addr_v[0] = 19'd10; addr_v[1] = 19'd20; addr_v[2] = 19'd30;
      req_v = 3'b111;
      for (int c = 1; c <= 10; c++) begin
         tick();
         eg = N'(1) << ((c - 1) % 3);
         ea = AW'(10 * ((c - 1) % 3 + 1));
         n_checks++;
         if (bus.grant_out !== eg || bus.bram_addr_out !== ea) begin
            n_fail++; $display("FAIL all3_grant cyc=%0d got=%b/%0d exp=%b/%0d", c, bus.grant_out, bus.bram_addr_out, eg, ea);
         end
         if (c >= 4) begin
            eg = N'(1) << ((c - 4) % 3);
            ea = AW'(10 * ((c - 4) % 3 + 1));
            n_checks++;
            if (bus.rd_valid_out !== eg || bus.rd_data_out !== bram_fn(ea)) begin
               n_fail++; $display("FAIL all3_ret cyc=%0d got=%b/%b exp=%b/%b", c, bus.rd_valid_out, bus.rd_data_out, eg, bram_fn(ea));
            end
         end
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL all3_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
   endtask

   task automatic test_two();
      logic [N-1:0] eg;
      do_reset();
      addr_v[0] = 19'd40; addr_v[1] = 19'd45; addr_v[2] = 19'd50;
      req_v = 3'b101;
      for (int c = 1; c <= 8; c++) begin
         tick();
         eg = (c % 2 == 1) ? 3'b001 : 3'b100;
         n_checks++;
         if (bus.grant_out !== eg) begin n_fail++; $display("FAIL two_grant cyc=%0d got=%b exp=%b", c, bus.grant_out, eg); end
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL two_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      addr_v[1] = 19'd60; addr_v[2] = 19'd70;
      req_v = 3'b110;
      tick();
      n_checks++; if (bus.grant_out !== 3'b010) begin n_fail++; $display("FAIL rmid_g1 got=%b exp=010", bus.grant_out); end
      req_v = 3'b100;
      tick();
      n_checks++; if (bus.grant_out !== 3'b100) begin n_fail++; $display("FAIL rmid_g2 got=%b exp=100", bus.grant_out); end
      req_v = 3'b000;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.grant_out !== 3'b000 || bus.bram_addr_out !== 19'd0 || bus.rd_valid_out !== 3'b000 ||
          bus.rd_data_out !== 1'b0 || bus.idle_out !== 1'b1) begin
         n_fail++; $display("FAIL rmid_reset got=%h exp=%h", obs_vec, {3'b000, 19'd0, 3'b000, 1'b0, 1'b1});
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (bus.rd_valid_out !== 3'b000) begin n_fail++; $display("FAIL rmid_stale cyc=%0d got=%b exp=000", c, bus.rd_valid_out); end
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rmid_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      addr_v[0] = 19'd80; addr_v[1] = 19'd90;
      req_v = 3'b011;
      tick();
      n_checks++; if (bus.grant_out !== 3'b001) begin n_fail++; $display("FAIL wd_g1 got=%b exp=001", bus.grant_out); end
      req_v = 3'b001;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (bus.grant_out[1] !== 1'b0 || bus.rd_valid_out[1] !== 1'b0) begin
            n_fail++; $display("FAIL wd_req1 cyc=%0d got=%b/%b exp=0/0", c, bus.grant_out[1], bus.rd_valid_out[1]);
         end
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wd_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
   endtask

   task automatic test_stress();
      int            wait_c [N];
      int            max_wait;
      int            sb_idx [$];
      logic [AW-1:0] sb_addr [$];
      int            gi;
      logic [AW-1:0] ga;
      do_reset();
      max_wait = 0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         tick();
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stress_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
         for (int i = 0; i < N; i++)
            if (bus.grant_out[i]) begin sb_idx.push_back(i); sb_addr.push_back(bus.bram_addr_out); end
         if (bus.rd_valid_out != '0) begin
            n_checks++;
            if (sb_idx.size() == 0) begin
               n_fail++; $display("FAIL stress_sb cyc=%0d got=%b exp=none", c, bus.rd_valid_out);
            end else begin
               gi = sb_idx.pop_front();
               ga = sb_addr.pop_front();
               if (bus.rd_valid_out !== N'(1) << gi || bus.rd_data_out !== bram_fn(ga)) begin
                  n_fail++; $display("FAIL stress_sb cyc=%0d got=%b/%b exp=%b/%b", c, bus.rd_valid_out, bus.rd_data_out, N'(1) << gi, bram_fn(ga));
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_v[i] && !bus.grant_out[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
         end
         for (int i = 0; i < N; i++) begin
            if (req_v[i]) begin
               if (bus.grant_out[i]) begin
                  if ($urandom_range(0, 3) != 0) addr_v[i] = AW'($urandom());
                  else req_v[i] = 1'b0;
               end else if ($urandom_range(0, 31) == 0) begin
                  req_v[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req_v[i] = 1'b1;
               addr_v[i] = AW'($urandom());
            end
         end
      end
      req_v = '0;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++;
         if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL drain_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
         if (bus.rd_valid_out != '0 && sb_idx.size() != 0) begin
            void'(sb_idx.pop_front());
            void'(sb_addr.pop_front());
         end
      end
      n_checks++; if (sb_idx.size() != 0) begin n_fail++; $display("FAIL stress_left got=%0d exp=0", sb_idx.size()); end
      n_checks++; if (max_wait > N) begin n_fail++; $display("FAIL stress_starve got=%0d exp<=%0d", max_wait, N); end
      n_checks++; if (bus.idle_out !== 1'b1) begin n_fail++; $display("FAIL stress_idle got=%b exp=1", bus.idle_out); end
   endtask

   initial begin
      for (int i = 0; i < N; i++) addr_v[i] = '0;
      test_reset();
      test_single();
      test_all_three();
      test_two();
      test_reset_mid();
      test_withdraw();
      test_stress();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
